// File: rtl/johnson_pkg.sv
// Shared encodings for the Johnson ring sequencer.
package johnson_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_core.sv
// Johnson (twisted-ring) register: synchronous clear, enabled advance in either direction.
module johnson_core
   import johnson_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] out
);

   // clr wins over en so a restart always begins from the all-zero state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out <= '0;
      end else if (clr) begin
         out <= '0;
      end else if (en) begin
         if (dir == DIR_REV) out <= {~out[0], out[WIDTH-1:1]};
         else                out <= {out[WIDTH-2:0], ~out[WIDTH-1]};
      end
   end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run/pause/step/abort sequencer around a Johnson ring, with revolution counting,
// busy/done status and a decoded phase index.
module johnson_seq_ctrl
   import johnson_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned PH_W  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   input  logic             dir,
   input  logic [CNT_W-1:0] num_rev,
   output logic [WIDTH-1:0] out,
   output logic [PH_W-1:0]  phase,
   output logic             busy,
   output logic             done
);

   state_t            state;
   logic [CNT_W-1:0]  rev_left;
   logic              clr_c;
   logic              adv_c;
   logic              wrap_c;
   logic [WIDTH-1:0]  nxt_c;
   int unsigned       ones_c;

   johnson_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_c),
      .en    (adv_c),
      .dir   (dir),
      .out   (out)
   );

   // Ring control: priority stop > start > step; a wrap is an advance landing on zero
   always_comb begin
      clr_c = 1'b0;
      adv_c = 1'b0;
      unique case (state)
         ST_IDLE:   clr_c = start;
         ST_RUN:    adv_c = !stop;
         ST_PAUSED: begin
            clr_c = stop;
            adv_c = step && !stop && !start;
         end
         default:   ;
      endcase
      if (dir == DIR_REV) nxt_c = {~out[0], out[WIDTH-1:1]};
      else                nxt_c = {out[WIDTH-2:0], ~out[WIDTH-1]};
      wrap_c = adv_c && (nxt_c == '0);
   end

   // Sequencer state, revolution counter and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         rev_left <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_RUN;
                  rev_left <= num_rev;
                  busy     <= 1'b1;
               end
            end
            ST_RUN: begin
               if (stop) state <= ST_PAUSED;
            end
            ST_PAUSED: begin
               if (stop) begin
                  state    <= ST_IDLE;
                  rev_left <= '0;
                  busy     <= 1'b0;
               end else if (start) begin
                  state <= ST_RUN;
               end
            end
            default: state <= ST_IDLE;
         endcase
         // rev_left == 0 during a run means free-run, so wraps are not counted
         if (wrap_c && (rev_left != '0)) begin
            rev_left <= rev_left - CNT_W'(1);
            if (rev_left == CNT_W'(1)) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end

   // Phase: k ones with msb clear is position k, otherwise 2*WIDTH-k
   always_comb begin
      ones_c = 0;
      for (int i = 0; i < int'(WIDTH); i++) ones_c = ones_c + 32'(out[i]);
      if (out[WIDTH-1]) phase = PH_W'(2 * WIDTH - ones_c);
      else              phase = PH_W'(ones_c);
   end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl (WIDTH=4) with hand-computed ring sequences.
module tb_johnson_seq_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic       step;
   logic       dir;
   logic [7:0] num_rev;
   logic [3:0] out;
   logic [2:0] phase;
   logic       busy;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] fwd_seq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
   logic [3:0] rev_seq [8] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
   logic [2:0] rev_ph  [8] = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

   johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8), .PH_W(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .stop    (stop),
      .step    (step),
      .dir     (dir),
      .num_rev (num_rev),
      .out     (out),
      .phase   (phase),
      .busy    (busy),
      .done    (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int done_seen;

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
      dir = 1'b0; num_rev = 8'd0;
      #1;
      check("rst_out", 32'(out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_phase", 32'(phase), 32'h0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // Test 1: async reset in the middle of a run
      num_rev = 8'd1; dir = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_busy", 32'(busy), 32'h1);
      tick(); tick(); tick();
      check("t1_out_pre", 32'(out), 32'h7);
      #2 reset = 1'b1;
      #1;
      check("t1_out", 32'(out), 32'h0);
      check("t1_busy0", 32'(busy), 32'h0);
      check("t1_done", 32'(done), 32'h0);
      check("t1_phase", 32'(phase), 32'h0);
      #1 reset = 1'b0;
      tick();

      // Test 2: one forward revolution; num_rev change after start is ignored
      num_rev = 8'd1; dir = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; num_rev = 8'd5;
      check("t2_out0", 32'(out), 32'h0);
      check("t2_busy0", 32'(busy), 32'h1);
      for (int i = 1; i < 8; i++) begin
         tick();
         check($sformatf("t2_out%0d", i), 32'(out), 32'(fwd_seq[i]));
         check($sformatf("t2_ph%0d", i), 32'(phase), 32'(i));
         check($sformatf("t2_busy%0d", i), 32'(busy), 32'h1);
         check($sformatf("t2_done%0d", i), 32'(done), 32'h0);
      end
      tick();
      check("t2_out_end", 32'(out), 32'h0);
      check("t2_ph_end", 32'(phase), 32'h0);
      check("t2_busy_end", 32'(busy), 32'h0);
      check("t2_done_end", 32'(done), 32'h1);
      tick();
      check("t2_done_clr", 32'(done), 32'h0);
      check("t2_out_idle", 32'(out), 32'h0);

      // Test 3: two reverse revolutions
      num_rev = 8'd2; dir = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         check($sformatf("t3_out%0d", i), 32'(out), 32'(rev_seq[i % 8]));
         check($sformatf("t3_ph%0d", i), 32'(phase), 32'(rev_ph[i % 8]));
         check($sformatf("t3_done%0d", i), 32'(done), (i == 16) ? 32'h1 : 32'h0);
         check($sformatf("t3_busy%0d", i), 32'(busy), (i == 16) ? 32'h0 : 32'h1);
      end
      tick();
      check("t3_done_clr", 32'(done), 32'h0);

      // Test 4: pause, hold, single steps, resume
      num_rev = 8'd1; dir = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      check("t4_pre", 32'(out), 32'h3);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t4_stop_out", 32'(out), 32'h3);
      check("t4_stop_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t4_hold%0d", i), 32'(out), 32'h3);
      end
      step = 1'b1;
      tick(); check("t4_step1", 32'(out), 32'h7);
      tick(); check("t4_step2", 32'(out), 32'hF);
      tick(); check("t4_step3", 32'(out), 32'hE);
      step = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_resume_hold", 32'(out), 32'hE);
      tick(); check("t4_run1", 32'(out), 32'hC);
      check("t4_run1_done", 32'(done), 32'h0);
      tick(); check("t4_run2", 32'(out), 32'h8);
      tick(); check("t4_run3", 32'(out), 32'h0);
      check("t4_done", 32'(done), 32'h1);
      check("t4_busy", 32'(busy), 32'h0);
      tick();

      // Test 5: start+stop while paused aborts; later step ignored
      num_rev = 8'd1; dir = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t5_paused", 32'(out), 32'h7);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("t5_abort_out", 32'(out), 32'h0);
      check("t5_abort_busy", 32'(busy), 32'h0);
      check("t5_abort_done", 32'(done), 32'h0);
      step = 1'b1;
      tick();
      step = 1'b0;
      check("t5_step_out", 32'(out), 32'h0);
      check("t5_step_busy", 32'(busy), 32'h0);

      // Test 6: free-run, then stop, stop
      num_rev = 8'd0; dir = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      done_seen = 0;
      for (int i = 1; i <= 41; i++) begin
         tick();
         if (done) done_seen++;
         check($sformatf("t6_out%0d", i), 32'(out), 32'(fwd_seq[i % 8]));
      end
      check("t6_no_done", 32'(done_seen), 32'h0);
      check("t6_busy", 32'(busy), 32'h1);
      stop = 1'b1;
      tick();
      check("t6_pause_out", 32'(out), 32'h1);
      check("t6_pause_busy", 32'(busy), 32'h1);
      tick();
      stop = 1'b0;
      check("t6_abort_out", 32'(out), 32'h0);
      check("t6_abort_busy", 32'(busy), 32'h0);
      check("t6_abort_done", 32'(done), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
Sequencer for a WIDTH-bit Johnson (twisted-ring) counter. Starts, pauses, single-steps, resumes and aborts the ring. Runs a programmed number of full revolutions (2*WIDTH states each) or free-runs, and reports busy/done status.
Exports the ring value and a decoded phase index to downstream phase-timed logic.

Parameters:
WIDTH, 4, Johnson ring width in bits (>=2); one revolution = 2*WIDTH advances
CNT_W, 8, width of the revolution-count programming field
PH_W, 3, phase index width; must be >= clog2(2*WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  pulse: begin run from IDLE, resume from PAUSED
stop  input  1  pulse: pause from RUN, abort from PAUSED
step  input  1  pulse: single advance while PAUSED
dir  input  1  0 = forward (shift left, inject ~msb), 1 = reverse (shift right, inject ~lsb)
num_rev  input  CNT_W  revolutions to run; 0 = free-run until aborted
out  output  WIDTH  current Johnson ring value
phase  output  PH_W  decoded position 0..2*WIDTH-1 of out
busy  output  1  high in RUN or PAUSED
done  output  1  one-cycle pulse when programmed revolutions complete

Behaviour:
- Reset (async, any state): state=IDLE, out=0, busy=0, done=0, rev_left=0.
- Forward advance: out <= {out[WIDTH-2:0], ~out[WIDTH-1]}. Forward sequence for WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000,0000.
- Reverse advance: out <= {~out[0], out[WIDTH-1:1]}. Gives the exact reverse sequence.
- dir is sampled live at every advance. Changing direction mid-run is legal.
- phase (combinational): let k = number of ones in out. If out[WIDTH-1]=0, phase=k; otherwise phase=2*WIDTH-k.
- States: IDLE, RUN, PAUSED.
- IDLE + start at edge n:
  - out<=0, rev_left<=num_rev, state<=RUN, busy=1 after edge n.
  - First advance at edge n+1.
- RUN: one advance per clock.
- Revolution counting: an advance whose result is all-zero is a wrap.
  - On a wrap with num_rev!=0, rev_left decrements.
  - When rev_left reaches 0: state<=IDLE, busy<=0, done=1 for exactly one cycle (same edge). out stays 0.
- RUN + stop: state<=PAUSED. No advance on that edge. out and rev_left hold.
- PAUSED + step: exactly one advance, counted as in RUN. The final wrap from a step completes the run (done pulses, goes to IDLE).
- PAUSED + start: state<=RUN. Advancing resumes on the following edge. rev_left is not reloaded.
- PAUSED + stop: abort. state<=IDLE, out<=0, busy<=0, done stays 0.
- Simultaneous pulses: stop beats start, start beats step. Priority is stop > start > step.
- start in RUN is ignored. step in IDLE or RUN is ignored. stop in IDLE is ignored.
- num_rev is sampled only when starting from IDLE. Later changes are ignored until the next run.
- Free-run (num_rev=0): wraps are not counted, done never asserts. Exit only via stop followed by stop.
- Max run length: (2^CNT_W - 1)*2*WIDTH advances. There is no internal overflow.

Decomposition:
- Shared package/header johnson_pkg:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSED (2-bit);
  - direction constants DIR_FWD=0, DIR_REV=1.
- One sub-module: johnson_core. It holds only the ring register.
  - Inputs: clk, reset, clr, en, dir.
  - Output: out.
  - clr has priority over en.
- johnson_seq_ctrl contains the FSM, rev_left counter, wrap detect, phase decode and done pulse.

Test Plan:
1. Reset during RUN at out=0111 -> out=0000, busy=0, done=0, phase=0 immediately, without waiting for a clock edge.
2. WIDTH=4, num_rev=1, dir=0, start at edge n -> out steps 0001..1000 on edges n+1..n+7, then 0000 at n+8. done=1 only for the cycle after n+8, busy=0 from n+8. phase reads 1..7,0.
3. num_rev=2, dir=1 -> out after start sequence is 1000,1100,1110,1111,0111,0011,0001,0000 (twice). done after the 16th advance.
4. num_rev=1, stop after out=0011 -> out holds 0011 for 5 idle cycles.
   - Three step pulses -> out goes 0111, 1111, 1110.
   - Then start -> advances resume, and done fires after 8 total advances.
5. PAUSED at 0111 with start and stop in the same cycle -> abort wins: out=0000, busy=0, no done. A later step is ignored.
6. num_rev=0 free-run for 40 cycles -> out wraps repeatedly and done stays 0. Then stop, stop -> IDLE with out=0000.
